// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
//   Shared definitions for the memory-stage load/store unit:
//   funct3 load/store encodings, access size codes, LSU state encoding
//   and the alignment check helper.
package mem_stage_lsu_pkg;

    // Load encodings of funct3 (instr[14:12])
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_RSV = 3'b111
    } load_funct3_e;

    // Store encodings of funct3 (only bits 1:0 carry the size)
    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010,
        F3_SD = 3'b011
    } store_funct3_e;

    // Access size, taken from funct3[1:0]
    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

    // An access is misaligned when the byte offset is not a multiple of its size
    function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// lsu_load_align
//   Combinational load extractor: shifts the 64-bit bus word down to the
//   addressed byte lane and sign/zero-extends according to funct3.
//   Ports:
//     rdata  in  64  raw read data from the bus (8-byte aligned word)
//     offset in  3   byte offset of the access within the word
//     funct3 in  3   load type (LB/LH/LW/LD/LBU/LHU/LWU; 111 behaves as LD)
//     valM   out 64  extended load result
module lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] valM
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   valM = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   valM = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   valM = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  valM = {56'd0, shifted[7:0]};
            F3_LHU:  valM = {48'd0, shifted[15:0]};
            F3_LWU:  valM = {32'd0, shifted[31:0]};
            default: valM = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Memory-stage load/store unit. Takes the E->M register outputs, issues a
//   single request on a valid/ready data bus, waits for the response (or the
//   store write-ack), extends load data and stalls the pipeline meanwhile.
//   Parameter:
//     TIMEOUT  response-wait cycles before a bus error is forced (0 = never)
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     regM_i_valE/valB          effective address / lane-0 store data
//     regM_i_mem_ren/wen        load / store request (both set = store)
//     regM_i_mem_wmask          lane-0 store byte mask
//     regM_i_instr              instruction, funct3 in bits 14:12
//     dbus_o_req_valid/i_req_ready  request handshake
//     dbus_o_addr/wen/wdata/wstrb   aligned request fields
//     dbus_i_resp_valid/rdata/err   response channel
//     lsu_o_stall               freeze IF..M pipeline registers
//     lsu_o_valM                extended load result to M->W
//     lsu_o_done/misalign/bus_err   single-cycle status pulses
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] regM_i_valE,
    input  logic [63:0] regM_i_valB,
    input  logic        regM_i_mem_ren,
    input  logic        regM_i_mem_wen,
    input  logic [7:0]  regM_i_mem_wmask,
    input  logic [31:0] regM_i_instr,
    output logic        dbus_o_req_valid,
    input  logic        dbus_i_req_ready,
    output logic [63:0] dbus_o_addr,
    output logic        dbus_o_wen,
    output logic [63:0] dbus_o_wdata,
    output logic [7:0]  dbus_o_wstrb,
    input  logic        dbus_i_resp_valid,
    input  logic [63:0] dbus_i_resp_rdata,
    input  logic        dbus_i_resp_err,
    output logic        lsu_o_stall,
    output logic [63:0] lsu_o_valM,
    output logic        lsu_o_done,
    output logic        lsu_o_misalign,
    output logic        lsu_o_bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [7:0]       wstrb_q;
    logic             wen_q;
    logic [2:0]       off_q;
    logic [2:0]       f3_q;
    logic             err_q;
    logic [63:0]      valm_q;

    logic        access;
    logic        misaligned;
    logic        accept;
    logic        timeout_hit;
    logic [2:0]  off;
    logic [2:0]  funct3;
    logic [63:0] load_val;
    logic        unused_instr;

    assign off          = regM_i_valE[2:0];
    assign funct3       = regM_i_instr[14:12];
    assign access       = regM_i_mem_ren | regM_i_mem_wen;
    assign misaligned   = is_misaligned(size_e'(funct3[1:0]), off);
    assign accept       = access & ~misaligned;
    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_instr = ^{regM_i_instr[31:15], regM_i_instr[11:0]};

    // Extraction works from the registered offset/funct3 so the result does
    // not depend on regM contents while the access is in flight.
    lsu_load_align u_load_align (
        .rdata  (dbus_i_resp_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .valM   (load_val)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= LSU_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (accept) state_d = LSU_REQ;
            LSU_REQ:  if (dbus_i_req_ready) state_d = LSU_RESP;
            LSU_RESP: if (dbus_i_resp_valid || timeout_hit) state_d = LSU_DONE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Output logic; the status pulses and stall are forced low during reset
    always_comb begin
        dbus_o_req_valid = (state_q == LSU_REQ);
        lsu_o_stall      = 1'b0;
        lsu_o_done       = 1'b0;
        lsu_o_bus_err    = 1'b0;
        lsu_o_misalign   = 1'b0;
        if (!rst) begin
            case (state_q)
                LSU_IDLE: begin
                    lsu_o_stall    = accept;
                    lsu_o_misalign = access & misaligned;
                end
                LSU_REQ, LSU_RESP: lsu_o_stall = 1'b1;
                default: begin
                    lsu_o_done    = 1'b1;
                    lsu_o_bus_err = err_q;
                end
            endcase
        end
    end

    // Request fields, timeout counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
            off_q   <= '0;
            f3_q    <= '0;
            err_q   <= 1'b0;
            valm_q  <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (accept) begin
                        addr_q  <= {regM_i_valE[63:3], 3'b000};
                        wen_q   <= regM_i_mem_wen;
                        wdata_q <= regM_i_valB << {off, 3'b000};
                        wstrb_q <= regM_i_mem_wen ? (regM_i_mem_wmask << off) : '0;
                        off_q   <= off;
                        f3_q    <= funct3;
                        err_q   <= 1'b0;
                    end
                end
                LSU_REQ: begin
                    if (dbus_i_req_ready) cnt_q <= '0;
                end
                LSU_RESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dbus_i_resp_valid) begin
                        err_q  <= dbus_i_resp_err;
                        valm_q <= (!wen_q && !dbus_i_resp_err) ? load_val : '0;
                    end else if (timeout_hit) begin
                        err_q  <= 1'b1;
                        valm_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus_o_addr  = addr_q;
    assign dbus_o_wen   = wen_q;
    assign dbus_o_wdata = wdata_q;
    assign dbus_o_wstrb = wstrb_q;
    assign lsu_o_valM   = valm_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the E->M pipeline register outputs (address valE, store data valB, mem_ren, mem_wen, byte mask, instr) and drives the data-memory bus.
- Uses a valid/ready request channel and a valid response channel.
- Aligns and shifts store data/strobes, extracts and extends load data, and stalls the pipeline until the access completes.
- Output valM feeds the M->W register; stall freezes the upstream pipeline registers.

Parameters:
- TIMEOUT, 256: response-wait cycles before a bus error is forced; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- regM_i_valE  in  64  effective address
- regM_i_valB  in  64  store data, lane 0 aligned
- regM_i_mem_ren  in  1  load request
- regM_i_mem_wen  in  1  store request
- regM_i_mem_wmask  in  8  store byte mask, lane 0 aligned (01/03/0F/FF)
- regM_i_instr  in  32  instruction; funct3 = bits 14:12
- dbus_o_req_valid  out  1  request valid
- dbus_i_req_ready  in  1  request accepted
- dbus_o_addr  out  64  8-byte-aligned address (valE with bits 2:0 cleared)
- dbus_o_wen  out  1  1 = write
- dbus_o_wdata  out  64  valB shifted left by addr[2:0]*8
- dbus_o_wstrb  out  8  wmask shifted left by addr[2:0]; 0 for loads
- dbus_i_resp_valid  in  1  response/write-ack valid
- dbus_i_resp_rdata  in  64  read data
- dbus_i_resp_err  in  1  bus error with response
- lsu_o_stall  out  1  freeze IF..M pipeline registers
- lsu_o_valM  out  64  extended load result
- lsu_o_done  out  1  1-cycle pulse: access complete
- lsu_o_misalign  out  1  1-cycle pulse: misaligned access
- lsu_o_bus_err  out  1  1-cycle pulse: bus error or timeout

Behaviour:
- Reset (sync, active-high):
  - State IDLE, timeout counter 0.
  - dbus_o_req_valid=0, dbus_o_addr=0, dbus_o_wen=0, dbus_o_wdata=0, dbus_o_wstrb=0.
  - lsu_o_valM=0, lsu_o_done=0, lsu_o_misalign=0, lsu_o_bus_err=0.
  - lsu_o_stall=0 combinationally while in reset.
- Access present = ren | wen. If both are set, treat as a store and ignore the load.
- Size is taken from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double.
- Misaligned means addr[2:0] is not a multiple of the size. On a misaligned access:
  - no bus request is issued;
  - lsu_o_misalign pulses in the cycle the access is present in IDLE;
  - stall=0.
- States:
  - IDLE: stall = access & aligned. On an aligned access, register bus fields and go to REQ; otherwise stay.
  - REQ: req_valid=1, stall=1; fields are held stable until the handshake. On req_valid & req_ready, go to RESP and clear the counter.
  - RESP: stall=1, counter increments each cycle.
    - On resp_valid: for a load, capture the extended data into valM and latch resp_err; for a store, set valM=0. Go to DONE.
    - If TIMEOUT!=0 and counter==TIMEOUT-1 with no response: latch err=1, valM=0, go to DONE.
  - DONE: stall=0. Pulse done, plus bus_err if err was latched. Go to IDLE.
- The next regM contents are sampled only after DONE, so the same instruction is never reissued.
- Load extract: shift rdata right by addr[2:0]*8.
  - funct3 000 LB and 001 LH: sign-extend.
  - 010 LW: sign-extend.
  - 011 LD: no extension.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: treated as LD.
- Error: on bus error, valM=0 and done still pulses.
- Minimum latency (ready=1, response the cycle after acceptance): access in IDLE at c0, REQ c1, RESP c2, DONE c3. Stall is high in c0..c2.
- resp_valid outside RESP is ignored, including a stale response after a mid-operation reset.
- Reset mid-REQ/RESP returns to IDLE immediately; req_valid drops the next cycle.
- A store waits for resp_valid as its write ack.

Decomposition:
- Shared package/define file holds:
  - funct3 load/store encodings;
  - LSU state encodings (IDLE/REQ/RESP/DONE);
  - size codes.
- One combinational sub-module, lsu_load_align (rdata, offset, funct3 -> valM), which is reusable by a future cache.

Test Plan:
- LB at addr 0x1003, rdata 0x0000_0000_80FF_0000 with ready=1 and a 1-cycle response -> stall high 3 cycles; valM=0xFFFF_FFFF_FFFF_FF80; done pulses c3.
- SH at addr 0x2006, valB=0xABCD, wmask=03 -> dbus_o_addr=0x2000, wstrb=0xC0, wdata=0xABCD_0000_0000_0000, wen=1; done after ack.
- LW at addr 0x3002 (misaligned) -> no req_valid, misalign pulse, stall=0, valM unchanged.
- LD with req_ready low for 4 cycles -> req_valid, addr and wen stable for all 4 cycles; handshake on cycle 5; stall held throughout.
- LWU with TIMEOUT=8 and no response -> DONE after 8 RESP cycles; bus_err and done pulse; valM=0.
- rst asserted during RESP, then a stray resp_valid after reset -> state IDLE, all outputs zero, the stray response is ignored.
